// File: rtl/mux_sel_sequencer.sv
// ---------------------------------------------------------------------------
// mux_sel_sequencer
//
// Parallel-to-serial front end for an 8:1 bit multiplexer. A word is accepted
// over a valid/ready handshake and held on the mux data bus. The 3-bit select
// then steps through all eight positions, one position per hold period, so the
// mux output presents the word one bit at a time. A sample strobe with
// first/last markers tells the consumer when the mux output is stable.
//
// Parameters:
//   MSB_FIRST   0: select runs 0..7, 1: select runs 7..0
//   HOLD_CYCLES cycles each select value is held (legal range 1..16)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load_valid  load_data is valid
//   load_data   word to serialize
//   load_ready  sequencer accepts a word this cycle
//   abort       synchronous frame cancel (wins over load and counting)
//   sel         select to the mux
//   a           held word to the mux data input
//   bit_valid   mux output is stable, sample this cycle
//   bit_first   bit_valid for the first bit of the frame
//   bit_last    bit_valid for the last bit of the frame
//   busy        frame in progress
// ---------------------------------------------------------------------------
module mux_sel_sequencer #(
  parameter int MSB_FIRST   = 0,
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       abort,
  output logic [2:0] sel,
  output logic [7:0] a,
  output logic       bit_valid,
  output logic       bit_first,
  output logic       bit_last,
  output logic       busy
);

  // Hold counter is 4 bits wide, enough for HOLD_CYCLES up to 16.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] a_reg, a_next;
  logic [2:0] pos_reg, pos_next;
  logic [3:0] hold_cnt_reg, hold_cnt_next;

  logic hold_done;   // last cycle of the current select value
  logic frame_end;   // last cycle of the frame
  logic accept;

  assign hold_done = (state_reg == RUN) && (hold_cnt_reg == HOLD_LAST);
  assign frame_end = hold_done && (pos_reg == 3'd7);

  // Ready in IDLE, or on the final cycle of a frame so the next word starts
  // without a gap. abort masks it so a cancelled frame never chains a load.
  assign load_ready = !abort && ((state_reg == IDLE) || frame_end);
  assign accept     = load_valid && load_ready;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      a_reg        <= 8'h00;
      pos_reg      <= 3'd0;
      hold_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      pos_reg      <= pos_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    pos_next      = pos_reg;
    hold_cnt_next = hold_cnt_reg;

    if (abort) begin
      // In IDLE these are already the values held, so abort is a no-op there.
      state_next    = IDLE;
      pos_next      = 3'd0;
      hold_cnt_next = 4'd0;
    end else if (accept) begin
      // Covers both a load from IDLE and a chained load on frame_end.
      state_next    = RUN;
      a_next        = load_data;
      pos_next      = 3'd0;
      hold_cnt_next = 4'd0;
    end else if (state_reg == RUN) begin
      if (hold_done) begin
        hold_cnt_next = 4'd0;
        if (pos_reg == 3'd7) begin
          state_next = IDLE;
          pos_next   = 3'd0;
        end else begin
          pos_next = pos_reg + 3'd1;
        end
      end else begin
        hold_cnt_next = hold_cnt_reg + 4'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all decoded from registered state only
  // -------------------------------------------------------------------------
  logic [2:0] sel_run;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign sel_run = 3'd7 - pos_reg;
    end else begin : g_lsb_first
      assign sel_run = pos_reg;
    end
  endgenerate

  // Gate with RUN so an MSB-first sequencer does not park sel at 7 in IDLE.
  assign sel       = (state_reg == RUN) ? sel_run : 3'd0;
  assign a         = a_reg;
  assign bit_valid = hold_done;
  assign bit_first = hold_done && (pos_reg == 3'd0);
  assign bit_last  = frame_end;
  assign busy      = (state_reg == RUN);

endmodule

// File: doc/mux_sel_sequencer.md
# mux_sel_sequencer

Upstream driver for the 8:1 bit multiplexer, acting as a parallel-to-serial front end. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data bus. It then steps the 3-bit select through all eight positions, one position per hold period, so the mux output presents the word one bit at a time. A sample strobe, with first/last markers, tells the downstream consumer when the mux output is stable.

## Interface
- MSB_FIRST, 0, 0: select runs 0→7 (LSB first); 1: select runs 7→0.
- HOLD_CYCLES, 1, cycles each select value is held; legal range 1..16.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- load_valid  in  1  load_data is valid.
- load_data  in  8  word to serialize.
- load_ready  out  1  sequencer can accept a word this cycle.
- abort  in  1  synchronous frame cancel.
- sel  out  3  select to mux.
- a  out  8  held word to mux data input.
- bit_valid  out  1  strobe: mux output is stable and must be sampled this cycle.
- bit_first  out  1  qualifies bit_valid for the first bit of the frame.
- bit_last  out  1  qualifies bit_valid for the last bit of the frame.
- busy  out  1  frame in progress.

## Operation
- FSM states:
  - IDLE: no frame active.
  - RUN: frame active.
- Registers:
  - a_reg, 8 bits.
  - pos, 3 bits: bit index within the frame, counted from 0 regardless of direction.
  - hold_cnt, 0..HOLD_CYCLES-1.
- Accept: a word is taken when load_valid && load_ready.
- load_ready:
  - 1 in IDLE.
  - 1 in RUN only on the frame's final cycle (pos=7 && hold_cnt=HOLD_CYCLES-1).
  - Forced 0 whenever abort=1.
- On accept:
  - a_reg ← load_data.
  - pos ← 0, hold_cnt ← 0.
  - State ← RUN.
- sel output:
  - sel = pos when MSB_FIRST=0.
  - sel = 7−pos when MSB_FIRST=1.
  - sel = 0 in IDLE.
- a output: a = a_reg in all states. a_reg is not cleared at frame end and holds the last word.
- RUN counting:
  - hold_cnt increments each cycle.
  - At HOLD_CYCLES-1, hold_cnt wraps to 0 and pos increments.
  - At pos=7 with hold_cnt=HOLD_CYCLES-1:
    - If a new word is accepted that cycle, start the new frame next cycle with no gap.
    - Otherwise go to IDLE.
- Strobes (all registered-state decodes, no combinational path from inputs):
  - bit_valid = RUN && hold_cnt=HOLD_CYCLES-1.
  - bit_first = bit_valid && pos=0.
  - bit_last = bit_valid && pos=7.
- busy = (state==RUN).
- abort:
  - Takes priority over load and over normal counting.
  - Next cycle: state IDLE, pos=0, hold_cnt=0, a_reg unchanged.
  - No strobe is issued in the abort cycle's successor.
  - abort in IDLE is a no-op.
- load_valid while load_ready=0: ignored. The upstream must hold the word until it is accepted.
- HOLD_CYCLES=1: bit_valid is high on every RUN cycle.

## Timing
- Reset values (async assert, sync-safe deassert):
  - state IDLE.
  - sel=0, a=8'h00.
  - load_ready=1.
  - bit_valid=bit_first=bit_last=0.
  - busy=0.
- Reset mid-frame: outputs go to reset values immediately. No further strobes.
- Accept at cycle T:
  - a, sel and busy are valid from T+1.
  - First bit_valid at T+HOLD_CYCLES.
- Frame length: exactly 8×HOLD_CYCLES cycles of busy=1.
- Last strobe: at T+8×HOLD_CYCLES. That is the same cycle load_ready re-asserts during RUN.
- Back-to-back: sustained throughput is one word per 8×HOLD_CYCLES cycles, with zero idle cycles between frames.
- Strobe alignment: each strobe coincides with the last cycle sel holds its value. The mux output is settled by at least HOLD_CYCLES−1 cycles plus the combinational delay.

## Test plan
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle.
  - Required response: sel=0, a=00, load_ready=1, busy=0, all strobes 0, with no clock edge needed.
- LSB-first, HOLD_CYCLES=1:
  - Stimulus: load 8'hA5.
  - Required response: sel 0..7 on cycles T+1..T+8, mux out 1,0,1,0,0,1,0,1, bit_first at T+1, bit_last at T+8, IDLE at T+9.
- MSB_FIRST=1, HOLD_CYCLES=3:
  - Stimulus: load 8'h81.
  - Required response: each sel held 3 cycles, 7→0, strobes at T+3,6,…,24, sampled bits 1,0,0,0,0,0,0,1, busy high 24 cycles.
- Back-to-back:
  - Stimulus: 8'h0F then 8'hF0, load_valid held high.
  - Required response: the second word is accepted on the bit_last cycle of the first frame, sel wraps 7→0 with no gap, 16 consecutive strobes.
- Abort mid-frame:
  - Stimulus: abort at pos=3 with load_valid=1.
  - Required response: the word is not accepted, IDLE next cycle, no bit_last, sel=0, a still holds the old word, next load restarts at pos 0.
- Reset mid-frame:
  - Stimulus: rst_n low at pos=5 for 2 cycles, then release and load 8'h3C.
  - Required response: clean frame from pos 0, bits 0,0,1,1,1,1,0,0.
